s40dpra_npu_sram: RTL and testbench
===================================

S40DPRA_NPU_SRAM -- requirements
Module: s40dpra_npu_sram

Interface
REQ-001 The block SHALL have parameter WORDSWD, default 10, address width; depth = 2^WORDSWD words.
REQ-002 The block SHALL have parameter BITS, default 19, word width; variants 1024x19, 1024x64 and 128x64 are built through these parameters.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: CLK input 1, the single clock for both ports; RST input 1, the synchronous active-high reset.
REQ-004 The block SHALL have CENA/CENB, input, 1 bit, active-low chip enable per port.
REQ-005 The block SHALL have GWENA/GWENB, input, 1 bit, active-low global write enable.
REQ-006 The block SHALL have WENA/WENB, input, BITS wide, active-low per-bit write mask.
REQ-007 The block SHALL have AA/AB, input, WORDSWD wide, address.
REQ-008 The block SHALL have DA/DB, input, BITS wide, write data.
REQ-009 The block SHALL have QA/QB, output, BITS wide, registered read data.
REQ-010 The block SHALL have EMAA/EMAB (input, 3 bits) and EMAWA/EMAWB (input, 2 bits), timing margin inputs that are functionally ignored.
REQ-011 The block SHALL have TENA/TENB, input, 1 bit, active-low test-mux select: 0 selects the T* inputs.
REQ-012 The block SHALL have TCENA/TCENB, TGWENA/TGWENB, TWENA/TWENB, TAA/TAB and TDA/TDB, inputs, widths as their functional counterparts, test-mode controls and data.
REQ-013 The block SHALL have CENYA/CENYB, GWENYA/GWENYB, WENYA/WENYB and AYA/AYB, outputs, widths as their counterparts, carrying the post-mux controls combinationally.
REQ-014 The block SHALL have SIA/SIB (input, 2 bits), SEA/SEB (input, 1 bit) and SOA/SOB (output, 2 bits), the Q scan chain per port.
REQ-015 The block SHALL have DFTRAMBYP, input, 1 bit, array bypass; RET1N, input, 1 bit, active-low retention; COLLDISN, input, 1 bit, collision logic enable.

Function
REQ-016 Effective controls per port SHALL be the T* inputs when TENx=0 and the functional inputs otherwise; all rules below use the effective controls.
REQ-017 Access SHALL occur only at a CLK rising edge with RST=0, RET1N=1, SEx=0 and effective CEN=0.
REQ-018 Read (GWEN=1): Qx SHALL equal mem[A] one cycle later (latency 1); Qx SHALL hold its value when there is no read.
REQ-019 Write (GWEN=0): bit i of mem[A] SHALL be updated with D[i] only where WEN[i]=0; Qx SHALL be unchanged.
REQ-020 Address arithmetic SHALL be WORDSWD bits with no range check (all addresses valid).
REQ-021 DFTRAMBYP=1: writes SHALL be suppressed and a read SHALL return the effective D of the same port instead of mem.
REQ-022 Scan (SEx=1): each clock SHALL shift the low half of Qx up with SIx[0] entering bit 0 and the high half down with SIx[1] entering bit BITS-1; SOx[0]=Qx[BITS/2-1] and SOx[1]=Qx[BITS/2]. For odd BITS the low half is bits 0..BITS/2-1.
REQ-023 Collision means both ports are enabled at the same address in the same cycle with at least one write.
REQ-024 With COLLDISN=1: on a write/write collision port A data SHALL win for bits both ports write; on a read/write collision the read SHALL return old data.
REQ-025 With COLLDISN=0: write/write SHALL apply A then B (B wins); read/write SHALL be read-first (old data).
REQ-026 RET1N=0: no access or scan SHALL occur, and mem and Q SHALL be retained.

Reset
REQ-027 At a CLK edge with RST=1, QA and QB SHALL be set to 0 and no access SHALL occur in that cycle, including any write presented in that cycle.
REQ-028 Reset SHALL NOT clear the array; contents written before reset SHALL remain readable after reset.

Configuration
REQ-029 The block SHALL have macro SRAMDP_XDEBUG_EN; when it is defined the block SHALL print the instance path, WORDSWD and BITS at time 0 and print a message with the address on every collision.
REQ-030 When SRAMDP_XDEBUG_EN is not defined the block SHALL print nothing, and function SHALL be identical either way.

Verification
REQ-031 Write A addr 5 data 0x12345 with WENA all 0; read B addr 5 next cycle -> QB=0x12345 one cycle later.
REQ-032 mem[7]=0x7FFFF; write A addr 7 data 0 with WENA=0x7FF00 -> read gives 0x7FF00.
REQ-033 Same-cycle writes at addr 3, A=0x1, B=0x2: COLLDISN=1 -> mem[3]=0x1; COLLDISN=0 -> mem[3]=0x2.
REQ-034 Read A and write B at addr 9 with old value 0xAA, new 0x55 -> QA=0xAA, and a following read returns 0x55.
REQ-035 After a read has made QA nonzero, assert RST one cycle -> QA=0 and mem intact; TENA=0 with TAA=4 -> AYA=4 and access uses addr 4.
REQ-036 DFTRAMBYP=1, read A with DA=0x3C -> QA=0x3C and mem unchanged; RET1N=0 with a write presented -> no change.

Source files
------------

// File: rtl/s40dpra_npu_sram.sv
// Dual-port single-clock SRAM model with test mux, array bypass, Q scan and collision rules.
// Optional macro SRAMDP_XDEBUG_EN enables instance/collision messages; function is unchanged.
module s40dpra_npu_sram #(
    parameter int unsigned WORDSWD = 10,
    parameter int unsigned BITS    = 19
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CENA,
    input  logic               CENB,
    input  logic               GWENA,
    input  logic               GWENB,
    input  logic [BITS-1:0]    WENA,
    input  logic [BITS-1:0]    WENB,
    input  logic [WORDSWD-1:0] AA,
    input  logic [WORDSWD-1:0] AB,
    input  logic [BITS-1:0]    DA,
    input  logic [BITS-1:0]    DB,
    output logic [BITS-1:0]    QA,
    output logic [BITS-1:0]    QB,
    input  logic [2:0]         EMAA,
    input  logic [2:0]         EMAB,
    input  logic [1:0]         EMAWA,
    input  logic [1:0]         EMAWB,
    input  logic               TENA,
    input  logic               TENB,
    input  logic               TCENA,
    input  logic               TCENB,
    input  logic               TGWENA,
    input  logic               TGWENB,
    input  logic [BITS-1:0]    TWENA,
    input  logic [BITS-1:0]    TWENB,
    input  logic [WORDSWD-1:0] TAA,
    input  logic [WORDSWD-1:0] TAB,
    input  logic [BITS-1:0]    TDA,
    input  logic [BITS-1:0]    TDB,
    output logic               CENYA,
    output logic               CENYB,
    output logic               GWENYA,
    output logic               GWENYB,
    output logic [BITS-1:0]    WENYA,
    output logic [BITS-1:0]    WENYB,
    output logic [WORDSWD-1:0] AYA,
    output logic [WORDSWD-1:0] AYB,
    input  logic [1:0]         SIA,
    input  logic [1:0]         SIB,
    input  logic               SEA,
    input  logic               SEB,
    output logic [1:0]         SOA,
    output logic [1:0]         SOB,
    input  logic               DFTRAMBYP,
    input  logic               RET1N,
    input  logic               COLLDISN
);

    localparam int unsigned Depth = 2 ** WORDSWD;
    localparam int unsigned Lo    = BITS / 2;
    localparam logic [BITS-1:0] LoMask = {{(BITS - Lo){1'b0}}, {Lo{1'b1}}};
    localparam logic [BITS-1:0] HiMask = ~LoMask;

    logic [BITS-1:0] mem [Depth];

    logic               cen_a, cen_b;
    logic               gwen_a, gwen_b;
    logic [BITS-1:0]    wen_a, wen_b;
    logic [BITS-1:0]    d_a, d_b;
    logic [WORDSWD-1:0] a_a, a_b;
    logic               acc_a, acc_b;
    logic               rd_a, rd_b;
    logic               wr_a, wr_b;
    logic               same_addr;
    logic               ww_coll;
    logic [BITS-1:0]    coll_word;
    logic [BITS-1:0]    scan_a, scan_b;
    logic [BITS-1:0]    qa_q, qb_q;
    logic               unused_ok;

    assign cen_a  = TENA ? CENA  : TCENA;
    assign cen_b  = TENB ? CENB  : TCENB;
    assign gwen_a = TENA ? GWENA : TGWENA;
    assign gwen_b = TENB ? GWENB : TGWENB;
    assign wen_a  = TENA ? WENA  : TWENA;
    assign wen_b  = TENB ? WENB  : TWENB;
    assign a_a    = TENA ? AA    : TAA;
    assign a_b    = TENB ? AB    : TAB;
    assign d_a    = TENA ? DA    : TDA;
    assign d_b    = TENB ? DB    : TDB;

    assign CENYA  = cen_a;
    assign CENYB  = cen_b;
    assign GWENYA = gwen_a;
    assign GWENYB = gwen_b;
    assign WENYA  = wen_a;
    assign WENYB  = wen_b;
    assign AYA    = a_a;
    assign AYB    = a_b;

    assign acc_a = !RST && RET1N && !SEA && !cen_a;
    assign acc_b = !RST && RET1N && !SEB && !cen_b;
    assign rd_a  = acc_a && gwen_a;
    assign rd_b  = acc_b && gwen_b;
    assign wr_a  = acc_a && !gwen_a && !DFTRAMBYP;
    assign wr_b  = acc_b && !gwen_b && !DFTRAMBYP;

    assign same_addr = (a_a == a_b);
    assign ww_coll   = wr_a && wr_b && same_addr;

    function automatic logic [BITS-1:0] merge_word(input logic [BITS-1:0] old,
                                                   input logic [BITS-1:0] data,
                                                   input logic [BITS-1:0] wen);
        return (old & wen) | (data & ~wen);
    endfunction

    function automatic logic [BITS-1:0] scan_shift(input logic [BITS-1:0] q,
                                                   input logic [1:0]      si);
        logic [BITS-1:0] r;
        // Low half moves toward the MSB, high half toward the LSB.
        r = ((q << 1) & LoMask) | ((q >> 1) & HiMask);
        r[0]      = si[0];
        r[BITS-1] = si[1];
        return r;
    endfunction

    // The winning port is applied last so its bits land on top of the other port's.
    always_comb begin
        coll_word = '0;
        if (COLLDISN) begin
            coll_word = merge_word(merge_word(mem[a_a], d_b, wen_b), d_a, wen_a);
        end else begin
            coll_word = merge_word(merge_word(mem[a_a], d_a, wen_a), d_b, wen_b);
        end
    end

    assign scan_a = scan_shift(qa_q, SIA);
    assign scan_b = scan_shift(qb_q, SIB);

    always_ff @(posedge CLK) begin
        if (ww_coll) begin
            mem[a_a] <= coll_word;
        end else begin
            if (wr_a) begin
                mem[a_a] <= merge_word(mem[a_a], d_a, wen_a);
            end
            if (wr_b) begin
                mem[a_b] <= merge_word(mem[a_b], d_b, wen_b);
            end
        end
    end

    // Reads sample the array before this edge's writes, giving read-first behaviour.
    always_ff @(posedge CLK) begin
        if (RST) begin
            qa_q <= '0;
        end else if (RET1N) begin
            if (SEA) begin
                qa_q <= scan_a;
            end else if (rd_a) begin
                qa_q <= DFTRAMBYP ? d_a : mem[a_a];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            qb_q <= '0;
        end else if (RET1N) begin
            if (SEB) begin
                qb_q <= scan_b;
            end else if (rd_b) begin
                qb_q <= DFTRAMBYP ? d_b : mem[a_b];
            end
        end
    end

    assign QA  = qa_q;
    assign QB  = qb_q;
    assign SOA = {qa_q[Lo], qa_q[Lo-1]};
    assign SOB = {qb_q[Lo], qb_q[Lo-1]};

    assign unused_ok = ^{EMAA, EMAB, EMAWA, EMAWB};

`ifdef SRAMDP_XDEBUG_EN
    initial begin
        $display("%m: WORDSWD=%0d BITS=%0d", WORDSWD, BITS);
    end

    always @(posedge CLK) begin
        if (acc_a && acc_b && same_addr && (!gwen_a || !gwen_b)) begin
            $display("%m: collision at address 0x%0h", a_a);
        end
    end
`else
`endif

endmodule

// File: tb/tb_s40dpra_npu_sram.sv
// Self-checking bench for s40dpra_npu_sram: directed steps plus randomized traffic
// checked against a behavioural memory model.
module tb_s40dpra_npu_sram;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 19;

    logic          clk;
    logic          rst;
    logic          cena, cenb, gwena, gwenb;
    logic [DW-1:0] wena, wenb, da, db, qa, qb;
    logic [AW-1:0] aa, ab;
    logic [2:0]    emaa, emab;
    logic [1:0]    emawa, emawb;
    logic          tena, tenb, tcena, tcenb, tgwena, tgwenb;
    logic [DW-1:0] twena, twenb, tda, tdb;
    logic [AW-1:0] taa, tab;
    logic          cenya, cenyb, gwenya, gwenyb;
    logic [DW-1:0] wenya, wenyb;
    logic [AW-1:0] aya, ayb;
    logic [1:0]    sia, sib, soa, sob;
    logic          sea, seb;
    logic          dftrambyp, ret1n, colldisn;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] ref_mem [1024];
    logic [DW-1:0] ref_qa = '0;
    logic [DW-1:0] ref_qb = '0;

    s40dpra_npu_sram #(.WORDSWD(AW), .BITS(DW)) dut (
        .CLK(clk), .RST(rst),
        .CENA(cena), .CENB(cenb), .GWENA(gwena), .GWENB(gwenb),
        .WENA(wena), .WENB(wenb), .AA(aa), .AB(ab), .DA(da), .DB(db),
        .QA(qa), .QB(qb),
        .EMAA(emaa), .EMAB(emab), .EMAWA(emawa), .EMAWB(emawb),
        .TENA(tena), .TENB(tenb), .TCENA(tcena), .TCENB(tcenb),
        .TGWENA(tgwena), .TGWENB(tgwenb), .TWENA(twena), .TWENB(twenb),
        .TAA(taa), .TAB(tab), .TDA(tda), .TDB(tdb),
        .CENYA(cenya), .CENYB(cenyb), .GWENYA(gwenya), .GWENYB(gwenyb),
        .WENYA(wenya), .WENYB(wenyb), .AYA(aya), .AYB(ayb),
        .SIA(sia), .SIB(sib), .SEA(sea), .SEB(seb), .SOA(soa), .SOB(sob),
        .DFTRAMBYP(dftrambyp), .RET1N(ret1n), .COLLDISN(colldisn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] scan_ref(input logic [DW-1:0] q, input logic [1:0] si);
        logic [DW-1:0] n;
        for (int i = 0; i < DW; i++) begin
            if (i < DW / 2) n[i] = (i == 0) ? si[0] : q[i-1];
            else            n[i] = (i == DW - 1) ? si[1] : q[i+1];
        end
        return n;
    endfunction

    task automatic apply_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [DW-1:0] wen);
        for (int i = 0; i < DW; i++) begin
            if (!wen[i]) ref_mem[a][i] = d[i];
        end
    endtask

    // Reads take the pre-edge contents; writes are applied in priority order afterwards.
    task automatic model_step();
        logic          e_cen, e_gw, acc_a, acc_b;
        logic [DW-1:0] e_wen, e_d;
        logic [AW-1:0] e_a;
        e_cen = tena ? cena  : tcena;
        e_gw  = tena ? gwena : tgwena;
        e_wen = tena ? wena  : twena;
        e_d   = tena ? da    : tda;
        e_a   = tena ? aa    : taa;
        acc_a = !rst && ret1n && !sea && !e_cen;
        acc_b = !rst && ret1n && !seb && !cenb;
        if (rst) begin
            ref_qa = '0;
            ref_qb = '0;
        end else if (ret1n) begin
            if (sea) ref_qa = scan_ref(ref_qa, sia);
            else if (acc_a && e_gw) ref_qa = dftrambyp ? e_d : ref_mem[e_a];
            if (seb) ref_qb = scan_ref(ref_qb, sib);
            else if (acc_b && gwenb) ref_qb = dftrambyp ? db : ref_mem[ab];
        end
        if (!dftrambyp) begin
            if (colldisn) begin
                if (acc_b && !gwenb) apply_write(ab, db, wenb);
                if (acc_a && !e_gw)  apply_write(e_a, e_d, e_wen);
            end else begin
                if (acc_a && !e_gw)  apply_write(e_a, e_d, e_wen);
                if (acc_b && !gwenb) apply_write(ab, db, wenb);
            end
        end
    endtask

    task automatic idle();
        rst = 1'b0; cena = 1'b1; cenb = 1'b1; gwena = 1'b1; gwenb = 1'b1;
        wena = '1; wenb = '1; sea = 1'b0; seb = 1'b0; sia = '0; sib = '0;
        tena = 1'b1; tenb = 1'b1; tcena = 1'b1; tcenb = 1'b1; tgwena = 1'b1; tgwenb = 1'b1;
        dftrambyp = 1'b0; ret1n = 1'b1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("qa", qa, ref_qa);
        check("qb", qb, ref_qb);
        idle();
    endtask

    task automatic wr_a(input int a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        cena = 1'b0; gwena = 1'b0; aa = AW'(a); da = d; wena = m;
    endtask
    task automatic wr_b(input int a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        cenb = 1'b0; gwenb = 1'b0; ab = AW'(a); db = d; wenb = m;
    endtask
    task automatic rd_a(input int a);
        cena = 1'b0; gwena = 1'b1; aa = AW'(a);
    endtask
    task automatic rd_b(input int a);
        cenb = 1'b0; gwenb = 1'b1; ab = AW'(a);
    endtask

    initial begin
        emaa = 3'd2; emab = 3'd5; emawa = 2'd1; emawb = 2'd3;
        aa = '0; ab = '0; da = '0; db = '0;
        taa = '0; tab = '0; tda = '0; tdb = '0; twena = '1; twenb = '1;
        colldisn = 1'b1;
        idle();
        rst = 1'b1;
        tick();
        check("rst_qa", qa, 0);
        check("rst_qb", qb, 0);

        for (int i = 0; i < 16; i++) begin
            wr_a(i, DW'($urandom), '0);
            tick();
        end

        // Plain write on A then read on B.
        wr_a(5, 19'h12345, '0); tick();
        rd_b(5); tick();
        check("rd_b_addr5", qb, 19'h12345);

        // Per-bit mask keeps the upper bits.
        wr_a(7, 19'h7FFFF, '0); tick();
        wr_a(7, 19'h00000, 19'h7FF00); tick();
        rd_a(7); tick();
        check("mask_addr7", qa, 19'h7FF00);

        // Write/write collisions under both collision modes.
        colldisn = 1'b1;
        wr_a(3, 19'h1, '0); wr_b(3, 19'h2, '0); tick();
        rd_a(3); tick();
        check("coll_en_a_wins", qa, 19'h1);
        colldisn = 1'b0;
        wr_a(3, 19'h1, '0); wr_b(3, 19'h2, '0); tick();
        rd_a(3); tick();
        check("coll_dis_b_wins", qa, 19'h2);
        colldisn = 1'b1;

        // Read/write collision returns old data.
        wr_a(9, 19'hAA, '0); tick();
        rd_a(9); wr_b(9, 19'h55, '0); tick();
        check("rw_old_data", qa, 19'hAA);
        rd_a(9); tick();
        check("rw_new_data", qa, 19'h55);

        // Reset clears Q only and blocks a write presented in the same cycle.
        rst = 1'b1; wr_a(9, 19'h1, '0); tick();
        check("rst_mid_qa", qa, 0);
        rd_a(9); tick();
        check("rst_mem_kept", qa, 19'h55);

        // Test mux on port A; functional controls must be ignored.
        tena = 1'b0; tcena = 1'b0; tgwena = 1'b1; taa = AW'(4); aa = AW'(0);
        #1;
        check("aya_mux", aya, 4);
        check("cenya_mux", cenya, 0);
        check("gwenya_mux", gwenya, 1);
        tick();
        check("tmode_read", qa, ref_mem[4]);
        tena = 1'b0; tcena = 1'b0; tgwena = 1'b0; taa = AW'(4); tda = 19'h4444; twena = '0;
        wr_a(6, 19'h6666, '0);
        tick();
        rd_a(4); tick();
        check("tmode_write", qa, 19'h4444);

        // Bypass returns D and suppresses the other port's write.
        dftrambyp = 1'b1; rd_a(5); da = 19'h3C; wr_b(5, 19'h0, '0); tick();
        check("bypass_qa", qa, 19'h3C);
        rd_a(5); tick();
        check("bypass_mem_kept", qa, 19'h12345);

        // Retention: nothing changes.
        ret1n = 1'b0; wr_a(5, 19'h0, '0); rd_b(9); tick();
        check("ret_qa_hold", qa, 19'h12345);
        check("ret_qb_hold", qb, ref_qb);
        rd_a(5); tick();
        check("ret_mem_kept", qa, 19'h12345);

        // Scan shifting on port A while a write is presented.
        for (int i = 0; i < 6; i++) begin
            sea = 1'b1; sia = 2'($urandom); wr_a(5, 19'h0, '0);
            tick();
            check("soa", {30'd0, soa}, {30'd0, ref_qa[DW/2], ref_qa[DW/2-1]});
        end
        rd_a(5); tick();
        check("scan_mem_kept", qa, 19'h12345);

        // Randomized traffic over a small window to force collisions.
        for (int n = 0; n < 400; n++) begin
            cena = ($urandom_range(0, 3) == 0); gwena = 1'($urandom);
            wena = DW'($urandom); aa = AW'($urandom_range(0, 7)); da = DW'($urandom);
            cenb = ($urandom_range(0, 3) == 0); gwenb = 1'($urandom);
            wenb = DW'($urandom); ab = AW'($urandom_range(0, 7)); db = DW'($urandom);
            colldisn  = 1'($urandom);
            dftrambyp = ($urandom_range(0, 7) == 0);
            ret1n     = ($urandom_range(0, 15) != 0);
            rst       = ($urandom_range(0, 31) == 0);
            sea = ($urandom_range(0, 15) == 0); sia = 2'($urandom);
            seb = ($urandom_range(0, 15) == 0); sib = 2'($urandom);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            rd_a(i); rd_b(7 - i); tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
